// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the scratchpad stream reader.
package ram_stream_reader_pkg;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// Two-entry synchronous FIFO holding {last, data}; the caller never pops when empty
// and never pushes when full.
module ram_stream_reader_fifo
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0]      mem_d [FIFO_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + FIFO_CNT_W'(1);
      2'b01:   count_d = count_q - FIFO_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Scratchpad read initiator: walks LENGTH words from BASE_ADDR and streams them out.
// Define RAM_STREAM_READER_STRIDE_EN to use the stride port as the address increment.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned LEN_WIDTH    = 13,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_req,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;
  localparam int unsigned OCC_W   = FIFO_CNT_W + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] incr;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic                  inflight_q, inflight_d;
  logic                  pend_last_q, pend_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  req_c, last_issue_c, pop_c, push_c, push_last_c;
  logic [OCC_W-1:0]      occ_c;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [ENTRY_W-1:0]    fifo_head;

`ifdef RAM_STREAM_READER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  assign incr = stride_q;
`else
  logic unused_stride;
  assign unused_stride = ^stride;
  assign incr          = ADDR_WIDTH'(1);
`endif

  // Credit check counts FIFO entries plus the outstanding read, net of this cycle's pop.
  always_comb begin
    pop_c        = m_valid & m_ready;
    occ_c        = OCC_W'(fifo_count) + OCC_W'(inflight_q);
    last_issue_c = (issued_q == len_q - LEN_WIDTH'(1));
    req_c        = (state_q == RUN) && (occ_c < OCC_W'(FIFO_DEPTH) + OCC_W'(pop_c));

    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
`ifdef RAM_STREAM_READER_STRIDE_EN
    stride_d    = stride_q;
`endif
    inflight_d  = (READ_LATENCY == 1) ? req_c : 1'b0;
    pend_last_d = req_c & last_issue_c;
    push_c      = (READ_LATENCY == 1) ? inflight_q  : req_c;
    push_last_c = (READ_LATENCY == 1) ? pend_last_q : last_issue_c;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          len_d    = length;
          issued_d = '0;
`ifdef RAM_STREAM_READER_STRIDE_EN
          stride_d = stride;
`endif
          state_d  = (length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (req_c) begin
          addr_d   = addr_q + incr;
          issued_d = issued_q + LEN_WIDTH'(1);
          if (last_issue_c) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop_c && m_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
`ifdef RAM_STREAM_READER_STRIDE_EN
      stride_q    <= '0;
`endif
      inflight_q  <= 1'b0;
      pend_last_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
`ifdef RAM_STREAM_READER_STRIDE_EN
      stride_q    <= stride_d;
`endif
      inflight_q  <= inflight_d;
      pend_last_q <= pend_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  ram_stream_reader_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_c),
    .push_data({push_last_c, mem_read_data}),
    .pop      (pop_c),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign mem_read_req  = req_c;
  assign mem_read_addr = addr_q;
  assign m_valid       = (fifo_count != '0);
  assign m_data        = fifo_head[DATA_WIDTH-1:0];
  assign m_last        = fifo_head[DATA_WIDTH];

endmodule
